// File: rtl/tb4004_pkg.sv
// Shared definitions for the TB4004 program-counter path: default address
// width and the prioritised command encoding used by the PC sequencer.
package tb4004_pkg;

  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_STEP,
    CMD_STEP2,
    CMD_JUMP,
    CMD_CALL,
    CMD_RET
  } pc_cmd_e;

  // Resolve simultaneous strobes: ret > call > jump > step2 > step.
  function automatic pc_cmd_e decode_cmd(input logic step, input logic step2,
                                         input logic jump, input logic call,
                                         input logic ret);
    if (ret)        return CMD_RET;
    else if (call)  return CMD_CALL;
    else if (jump)  return CMD_JUMP;
    else if (step2) return CMD_STEP2;
    else if (step)  return CMD_STEP;
    else            return CMD_NOP;
  endfunction

endpackage

// File: rtl/stack_pc_ring_ret_ring.sv
// Return-address ring: DEPTH entries addressed by a write pointer, with a
// saturating occupancy counter. Callers pre-qualify push/pop for the policy.
module ret_ring #(
  parameter  int ADDR_W = 12,
  parameter  int DEPTH  = 3,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] tos,
  output logic [CNT_W-1:0]  depth,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  wptr_inc;
  logic [PTR_W-1:0]  wptr_dec;

  always_comb begin
    wptr_inc = (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
    wptr_dec = (wptr == '0) ? PTR_W'(DEPTH - 1) : wptr - PTR_W'(1);
  end

  assign tos   = mem[wptr_dec];
  assign full  = (depth == CNT_W'(DEPTH));
  assign empty = (depth == '0);

  // Pushing while full overwrites the oldest slot; popping while empty
  // still rewinds the pointer, so the counter saturates at both ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= push_addr;
      wptr      <= wptr_inc;
      if (!full) depth <= depth + CNT_W'(1);
    end else if (pop) begin
      wptr <= wptr_dec;
      if (!empty) depth <= depth - CNT_W'(1);
    end
  end

endmodule

// File: rtl/stack_pc_ring.sv
// Program counter with hardware return-address stack: step/step2/jump/call/ret
// with selectable wrap (4004-style) or strict overflow/underflow handling.
module stack_pc_ring
  import tb4004_pkg::*;
#(
  parameter  int ADDR_W    = ADDR_W_DEF,
  parameter  int DEPTH     = 3,
  parameter  int WRAP_MODE = 1,
  parameter  int CALL_LEN  = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              step2,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic              flag_clr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] tos_out,
  output logic [CNT_W-1:0]  depth_out,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf
);

  pc_cmd_e           cmd;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              udf_set;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] tos_raw;
  logic [ADDR_W-1:0] pc_next;

  assign cmd      = decode_cmd(step, step2, jump, call, ret);
  assign ret_addr = pc_out + ADDR_W'(CALL_LEN);
  assign ovf_set  = (cmd == CMD_CALL) && full;
  assign udf_set  = (cmd == CMD_RET) && empty;
  assign push     = (cmd == CMD_CALL) && (!full || WRAP_MODE != 0);
  assign pop      = (cmd == CMD_RET) && (!empty || WRAP_MODE != 0);
  assign tos_out  = (WRAP_MODE == 0 && empty) ? '0 : tos_raw;

  ret_ring #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (ret_addr),
    .tos       (tos_raw),
    .depth     (depth_out),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    pc_next = pc_out;
    unique case (cmd)
      CMD_STEP:  pc_next = pc_out + ADDR_W'(1);
      CMD_STEP2: pc_next = pc_out + ADDR_W'(2);
      CMD_JUMP:  pc_next = target;
      CMD_CALL:  if (push) pc_next = target;
      CMD_RET:   if (pop) pc_next = tos_raw;
      default:   pc_next = pc_out;
    endcase
  end

  // A flag event in the same cycle as flag_clr leaves the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      pc_out <= pc_next;
      ovf    <= ovf_set | (ovf & ~flag_clr);
      udf    <= udf_set | (udf & ~flag_clr);
    end
  end

endmodule
